// File: rtl/sr_latch_driver_pkg.sv
// Shared types and constants for the gated SR latch driver.
// FSM state encoding, command opcodes and a small elaboration helper.
package sr_drv_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StPulse,
      StHold,
      StCheck
   } state_e;

   localparam logic [1:0] OP_NOP = 2'b00;
   localparam logic [1:0] OP_RST = 2'b01;
   localparam logic [1:0] OP_SET = 2'b10;
   localparam logic [1:0] OP_ILL = 2'b11;

   function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/sr_latch_driver_if.sv
// Command/status handshake between control logic (master) and the latch driver (slave).
interface sr_latch_driver_if;

   logic       req_valid;
   logic [1:0] req_op;
   logic       req_ready;
   logic       busy;
   logic       done;
   logic       mismatch;
   logic       err;

   modport master (
      output req_valid,
      output req_op,
      input  req_ready,
      input  busy,
      input  done,
      input  mismatch,
      input  err
   );

   modport slave (
      input  req_valid,
      input  req_op,
      output req_ready,
      output busy,
      output done,
      output mismatch,
      output err
   );

endinterface

// File: rtl/sr_drv_timer.sv
// Loadable down-counter that saturates at zero; expired flags a zero count.
module sr_drv_timer #(
   parameter int unsigned CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (cnt_q == '0);

endmodule

// File: rtl/sr_latch_driver.sv
// Initiator for a gated SR latch: sequences S/R and enable with setup, pulse and hold
// spacing, then reads Q back and reports done/mismatch.
module sr_latch_driver
   import sr_drv_pkg::*;
#(
   parameter int unsigned SETUP_W = 1,
   parameter int unsigned PULSE_W = 4,
   parameter int unsigned HOLD_W  = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   sr_latch_driver_if.slave    bus,
   output logic                S,
   output logic                R,
   output logic                enable,
   input  logic                q_fb
);

   localparam int unsigned CNT_W = $clog2(max3(SETUP_W, PULSE_W, HOLD_W)) + 1;

   if (SETUP_W == 0 || PULSE_W == 0 || HOLD_W == 0) begin : g_bad_param
      $error("sr_latch_driver: SETUP_W, PULSE_W and HOLD_W must all be >= 1");
   end

   state_e           state_q, state_d;
   logic             s_q, s_d, r_q, r_d, en_q, en_d;
   logic             exp_q, exp_d;
   logic             busy_q, busy_d, done_q, done_d, err_q, err_d;
   logic             accept;
   logic             timer_load;
   logic [CNT_W-1:0] timer_val;
   logic             expired;

   assign accept = bus.req_valid && (state_q == StIdle);

   sr_drv_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (timer_load),
      .load_val (timer_val),
      .expired  (expired)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept && (bus.req_op == OP_SET || bus.req_op == OP_RST)) state_d = StSetup;
         StSetup: if (expired) state_d = StPulse;
         StPulse: if (expired) state_d = StHold;
         StHold:  if (expired) state_d = StCheck;
         StCheck: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Next values of the registered outputs plus timer reloads at each phase boundary.
   always_comb begin
      s_d        = s_q;
      r_d        = r_q;
      en_d       = en_q;
      exp_d      = exp_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      timer_load = 1'b0;
      timer_val  = '0;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               unique case (bus.req_op)
                  OP_SET: begin
                     s_d        = 1'b1;
                     r_d        = 1'b0;
                     exp_d      = 1'b1;
                     timer_load = 1'b1;
                     timer_val  = CNT_W'(SETUP_W - 1);
                  end
                  OP_RST: begin
                     s_d        = 1'b0;
                     r_d        = 1'b1;
                     exp_d      = 1'b0;
                     timer_load = 1'b1;
                     timer_val  = CNT_W'(SETUP_W - 1);
                  end
                  OP_NOP:  done_d = 1'b1;
                  default: err_d  = 1'b1;
               endcase
            end
         end
         StSetup: begin
            if (expired) begin
               en_d       = 1'b1;
               timer_load = 1'b1;
               timer_val  = CNT_W'(PULSE_W - 1);
            end
         end
         StPulse: begin
            if (expired) begin
               en_d       = 1'b0;
               timer_load = 1'b1;
               timer_val  = CNT_W'(HOLD_W - 1);
            end
         end
         StHold: begin
            if (expired) begin
               s_d    = 1'b0;
               r_d    = 1'b0;
               done_d = 1'b1;
            end
         end
         StCheck: ;
         default: ;
      endcase
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_q    <= 1'b0;
         r_q    <= 1'b0;
         en_q   <= 1'b0;
         exp_q  <= 1'b0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         s_q    <= s_d;
         r_q    <= r_d;
         en_q   <= en_d;
         exp_q  <= exp_d;
         busy_q <= busy_d;
         done_q <= done_d;
         err_q  <= err_d;
      end
   end

   assign S             = s_q;
   assign R             = r_q;
   assign enable        = en_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.req_ready = (state_q == StIdle);
   // Q must be observed during CHECK itself, so mismatch is decoded from state and q_fb.
   assign bus.mismatch  = (state_q == StCheck) && (q_fb != exp_q);

   a_no_overlap : assert property (@(posedge clk) disable iff (!rst_n) !(S && R));
   a_en_drive   : assert property (@(posedge clk) disable iff (!rst_n) enable |-> (S ^ R));
   a_done_err   : assert property (@(posedge clk) disable iff (!rst_n) !(bus.done && bus.err));
   a_busy_ready : assert property (@(posedge clk) disable iff (!rst_n)
                                   bus.busy == !bus.req_ready);
   a_sr_stable  : assert property (@(posedge clk) disable iff (!rst_n)
                                   (enable || $past(enable)) |-> ($stable(S) && $stable(R)));

endmodule

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver: per-scenario tasks check timing inline; a scoreboard queue holds
// the expected done/err outcome of each accepted command.
module tb_sr_latch_driver;
   import sr_drv_pkg::*;

   localparam int SETUP_W = 1;
   localparam int PULSE_W = 4;
   localparam int HOLD_W  = 1;
   localparam int TOTAL   = SETUP_W + PULSE_W + HOLD_W;

   typedef struct packed {
      logic is_err;
      logic mism;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic S, R, enable, q_fb;
   logic q_model = 1'b0;
   logic force_en = 1'b0;
   logic force_val = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;
   exp_t sb[$];

   sr_latch_driver_if bus ();

   sr_latch_driver #(
      .SETUP_W (SETUP_W),
      .PULSE_W (PULSE_W),
      .HOLD_W  (HOLD_W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus.slave),
      .S      (S),
      .R      (R),
      .enable (enable),
      .q_fb   (q_fb)
   );

   always #5 clk = ~clk;

   // Behavioural gated latch fed by the DUT drives.
   always @(posedge clk) begin
      if (enable) begin
         if (S) q_model <= 1'b1;
         else if (R) q_model <= 1'b0;
      end
   end

   assign q_fb = force_en ? force_val : q_model;

   // Invariants every cycle, and scoreboard pop on every done/err.
   always @(negedge clk) begin
      if (rst_n) begin
         exp_t e;
         vectors++;
         if (S && R) begin
            miscompares++;
            $display("FAIL sr_overlap: S=%b R=%b, required not both 1", S, R);
         end
         vectors++;
         if (enable && !(S ^ R)) begin
            miscompares++;
            $display("FAIL enable_drive: enable=%b S=%b R=%b, required S^R", enable, S, R);
         end
         vectors++;
         if (bus.busy !== !bus.req_ready) begin
            miscompares++;
            $display("FAIL busy_ready: busy=%b req_ready=%b, required complement",
                     bus.busy, bus.req_ready);
         end
         if (bus.done === 1'b1 || bus.err === 1'b1) begin
            vectors++;
            if (sb.size() == 0) begin
               miscompares++;
               $display("FAIL unexpected_result: done=%b err=%b, required no result",
                        bus.done, bus.err);
            end else begin
               e = sb.pop_front();
               if (bus.err !== e.is_err || bus.done !== !e.is_err ||
                   (!e.is_err && bus.mismatch !== e.mism)) begin
                  miscompares++;
                  $display("FAIL result: done=%b err=%b mismatch=%b, required done=%b err=%b mismatch=%b",
                           bus.done, bus.err, bus.mismatch, !e.is_err, e.is_err, e.mism);
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time expired, required completion");
      $fatal(1, "watchdog");
   end

   // Waits for req_ready, presents op and returns at the negedge after the accept edge.
   task automatic send(input logic [1:0] op, input logic exp_mism, input bit hold,
                       output bit ok);
      int n = 0;
      exp_t e;
      @(negedge clk);
      while (!bus.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      vectors++;
      if (bus.req_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL accept_timeout: req_ready=%b, required 1", bus.req_ready);
         ok = 1'b0;
         return;
      end
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      e.is_err = (op == OP_ILL);
      e.mism   = exp_mism;
      sb.push_back(e);
      @(posedge clk);
      @(negedge clk);
      if (!hold) bus.req_valid = 1'b0;
      ok = 1'b1;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = OP_NOP;
      repeat (3) @(negedge clk);
      vectors++;
      if (S !== 1'b0 || R !== 1'b0 || enable !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.busy !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_hold: S=%b R=%b en=%b ready=%b busy=%b, required 0 0 0 1 0",
                  S, R, enable, bus.req_ready, bus.busy);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      vectors++;
      if (S !== 1'b0 || R !== 1'b0 || enable !== 1'b0 || bus.req_ready !== 1'b1 ||
          bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_idle: S=%b R=%b en=%b ready=%b busy=%b done=%b err=%b, required 0 0 0 1 0 0 0",
                  S, R, enable, bus.req_ready, bus.busy, bus.done, bus.err);
      end
   endtask

   // One full write with cycle-by-cycle checks of S/R, enable, done and req_ready.
   task automatic test_write(input logic [1:0] op, input logic f_en, input logic f_val);
      bit   ok;
      logic want_s, want_r, want_en;
      force_en  = f_en;
      force_val = f_val;
      send(op, f_en ? (f_val != (op == OP_SET)) : 1'b0, 1'b0, ok);
      if (ok) begin
         for (int k = 0; k <= TOTAL + 1; k++) begin
            want_s  = (op == OP_SET) && (k < TOTAL);
            want_r  = (op == OP_RST) && (k < TOTAL);
            want_en = (k >= SETUP_W) && (k < SETUP_W + PULSE_W);
            vectors++;
            if (S !== want_s || R !== want_r) begin
               miscompares++;
               $display("FAIL sr_timing k=%0d: S=%b R=%b, required S=%b R=%b",
                        k, S, R, want_s, want_r);
            end
            vectors++;
            if (enable !== want_en) begin
               miscompares++;
               $display("FAIL enable_timing k=%0d: enable=%b, required %b", k, enable, want_en);
            end
            vectors++;
            if (bus.done !== (k == TOTAL)) begin
               miscompares++;
               $display("FAIL done_timing k=%0d: done=%b, required %b", k, bus.done, k == TOTAL);
            end
            vectors++;
            if (bus.req_ready !== (k > TOTAL)) begin
               miscompares++;
               $display("FAIL ready_timing k=%0d: req_ready=%b, required %b",
                        k, bus.req_ready, k > TOTAL);
            end
            @(negedge clk);
         end
      end
      force_en = 1'b0;
   endtask

   task automatic test_set_reset();
      test_write(OP_SET, 1'b0, 1'b0);
      test_write(OP_RST, 1'b0, 1'b0);
   endtask

   task automatic test_mismatch();
      test_write(OP_SET, 1'b1, 1'b0);
      test_write(OP_RST, 1'b1, 1'b1);
   endtask

   task automatic test_illegal_nop();
      bit ok;
      send(OP_ILL, 1'b0, 1'b0, ok);
      if (ok) begin
         vectors++;
         if (bus.err !== 1'b1 || S !== 1'b0 || R !== 1'b0 || enable !== 1'b0 ||
             bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL illegal_op: err=%b S=%b R=%b en=%b busy=%b, required 1 0 0 0 0",
                     bus.err, S, R, enable, bus.busy);
         end
         @(negedge clk);
         vectors++;
         if (bus.err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_pulse: err=%b, required 0", bus.err);
         end
      end
      // X on q_fb must not leak into a no-op result.
      force_en  = 1'b1;
      force_val = 1'bx;
      send(OP_NOP, 1'b0, 1'b0, ok);
      if (ok) begin
         vectors++;
         if (bus.done !== 1'b1 || bus.mismatch !== 1'b0 || bus.busy !== 1'b0 ||
             S !== 1'b0 || R !== 1'b0) begin
            miscompares++;
            $display("FAIL nop_op: done=%b mismatch=%b busy=%b S=%b R=%b, required 1 0 0 0 0",
                     bus.done, bus.mismatch, bus.busy, S, R);
         end
         @(negedge clk);
         vectors++;
         if (bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: done=%b, required 0", bus.done);
         end
      end
      force_en = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit   ok;
      int   n = 0;
      exp_t e;
      send(OP_SET, 1'b0, 1'b1, ok);
      if (ok) begin
         bus.req_op = OP_RST;
         e.is_err   = 1'b0;
         e.mism     = 1'b0;
         sb.push_back(e);
         while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
         end
         vectors++;
         if (n != TOTAL + 1) begin
            miscompares++;
            $display("FAIL b2b_ready: ready after %0d edges, required %0d", n, TOTAL + 1);
         end
         @(posedge clk);
         @(negedge clk);
         bus.req_valid = 1'b0;
         vectors++;
         if (R !== 1'b1 || S !== 1'b0 || bus.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_second: S=%b R=%b busy=%b, required 0 1 1", S, R, bus.busy);
         end
         repeat (TOTAL + 3) @(negedge clk);
      end
      bus.req_valid = 1'b0;
   endtask

   task automatic test_reset_mid_pulse();
      bit ok;
      send(OP_SET, 1'b0, 1'b0, ok);
      if (ok) begin
         repeat (SETUP_W + 1) @(negedge clk);
         vectors++;
         if (enable !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_pulse_pre: enable=%b, required 1", enable);
         end
         rst_n = 1'b0;
         #1;
         sb.delete();
         vectors++;
         if (S !== 1'b0 || R !== 1'b0 || enable !== 1'b0 || bus.busy !== 1'b0 ||
             bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL async_reset: S=%b R=%b en=%b busy=%b done=%b, required all 0",
                     S, R, enable, bus.busy, bus.done);
         end
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < TOTAL + 2; i++) begin
            vectors++;
            if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0 || S !== 1'b0 || enable !== 1'b0) begin
               miscompares++;
               $display("FAIL post_reset i=%0d: ready=%b busy=%b S=%b en=%b, required 1 0 0 0",
                        i, bus.req_ready, bus.busy, S, enable);
            end
            @(negedge clk);
         end
      end
   endtask

   initial begin
      bus.req_valid = 1'b0;
      bus.req_op    = OP_NOP;
      test_reset();
      test_set_reset();
      test_mismatch();
      test_illegal_nop();
      test_back_to_back();
      test_reset_mid_pulse();
      repeat (2) @(negedge clk);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
